// File: rtl/i2c_target_byte.sv
// I2C target that answers one 7-bit address and moves single bytes.
// It oversamples SCL/SDA on clk, accepts writes into rx_data and serves reads from tx_data.
//
// state       | meaning
// ------------+--------------------------------------------------
// IDLE        | bus free or not addressed, waiting for START
// ADDR        | shifting in address + R/W bit
// ADDR_ACK    | driving ACK for a matched address
// RX          | shifting in a write byte
// RX_ACK      | driving ACK for a received byte
// TX          | presenting read data bits on SDA
// TX_ACK      | SDA released, sampling master ACK/NACK
// WAIT_STOP   | ignoring SCL until START or STOP
module i2c_target_byte #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_RX        = 3'd3;
    localparam logic [2:0] S_RX_ACK    = 3'd4;
    localparam logic [2:0] S_TX        = 3'd5;
    localparam logic [2:0] S_TX_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx_shift;
    logic       r_rw;
    logic       r_ack_pend;
    logic       r_sda_oe;
    logic       r_tx_req;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_busy;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    // Sync flops reset high so that leaving reset never looks like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl      = r_scl_s2;
    assign w_sda      = r_sda_s2;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = ~r_sda_s2 & r_sda_d & w_scl;
    assign w_stop     = r_sda_s2 & ~r_sda_d & w_scl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rw       <= 1'b0;
            r_ack_pend <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_state    <= S_ADDR;
                r_bit_cnt  <= 3'd0;
                r_shift    <= 8'h00;
                r_sda_oe   <= 1'b0;
                r_ack_pend <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_sda_oe   <= 1'b0;
                r_ack_pend <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_shift[6:0] == SLAVE_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_sda;
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First fall drives ACK; second fall ends the 9th clock.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                r_tx_shift <= tx_data;
                                r_tx_req   <= 1'b1;
                                r_sda_oe   <= ~tx_data[7];
                                r_bit_cnt  <= 3'd0;
                                r_state    <= S_TX;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RX;
                            end
                        end
                    end
                    S_RX: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rx_data  <= {r_shift[6:0], w_sda};
                                r_rx_valid <= 1'b1;
                                r_ack_pend <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_pend) begin
                            r_sda_oe   <= 1'b1;
                            r_ack_pend <= 1'b0;
                            r_state    <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_RX;
                        end
                    end
                    S_TX: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_TX_ACK;
                            end else begin
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_sda_oe   <= ~r_tx_shift[6];
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) r_state    <= S_WAIT_STOP;
                            else       r_ack_pend <= 1'b1;
                        end else if (w_scl_fall && r_ack_pend) begin
                            r_tx_shift <= tx_data;
                            r_tx_req   <= 1'b1;
                            r_sda_oe   <= ~tx_data[7];
                            r_bit_cnt  <= 3'd0;
                            r_ack_pend <= 1'b0;
                            r_state    <= S_TX;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign tx_req   = r_tx_req;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_byte.sv
// Directed bench for i2c_target_byte: a bit-banged I2C master with a wired-AND SDA line.
module tb_i2c_target_byte;

    localparam int HALF = 20;
    localparam int HOLD = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sda_line;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_rxv = 0;
    int cnt_txr = 0;
    int cnt_oe  = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_byte #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (rx_valid) cnt_rxv <= cnt_rxv + 1;
        if (tx_req)   cnt_txr <= cnt_txr + 1;
        if (sda_oe)   cnt_oe  <= cnt_oe + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        wait_clk(HALF);
        scl_m = 1'b1;
        wait_clk(HALF);
        sda_m = 1'b0;
        wait_clk(HALF);
        scl_m = 1'b0;
        wait_clk(HOLD);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        wait_clk(HALF);
        scl_m = 1'b1;
        wait_clk(HALF);
        sda_m = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic clock_bit(input logic b, output logic seen, output logic oe_seen);
        sda_m = b;
        wait_clk(HALF);
        scl_m = 1'b1;
        wait_clk(HALF / 2);
        seen    = sda_line;
        oe_seen = sda_oe;
        wait_clk(HALF / 2);
        scl_m = 1'b0;
        wait_clk(HOLD);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
        clock_bit(1'b1, ack, o);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d, output logic oe9);
        logic s, o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s, o);
            d = {d[6:0], s};
        end
        clock_bit(~m_ack, s, oe9);
    endtask

    task automatic test_reset;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        wait_clk(5);
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req got=%b want=0", tx_req); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        rst = 1'b0;
        wait_clk(10);
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL post_reset_sda_oe got=%b want=0", sda_oe); end
    endtask

    task automatic test_write;
        logic ack;
        int rxv0;
        rxv0 = cnt_rxv;
        i2c_start;
        send_byte(8'hA0, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack got=%b want=0", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got=%b want=1", busy); end
        send_byte(8'h3C, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_data_ack got=%b want=0", ack); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL write_rx_data got=%h want=3c", rx_data); end
        n_cmp++; if (cnt_rxv - rxv0 !== 1) begin n_fail++; $display("FAIL write_rx_valid_cycles got=%0d want=1", cnt_rxv - rxv0); end
        i2c_stop;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got=%b want=0", busy); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL write_oe_after_stop got=%b want=0", sda_oe); end
    endtask

    task automatic test_read_nack;
        logic ack, oe9;
        logic [7:0] d;
        int txr0;
        tx_data = 8'hAB;
        txr0 = cnt_txr;
        i2c_start;
        send_byte(8'hA1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack got=%b want=0", ack); end
        read_byte(1'b0, d, oe9);
        n_cmp++; if (d !== 8'hAB) begin n_fail++; $display("FAIL read_byte got=%h want=ab", d); end
        n_cmp++; if (oe9 !== 1'b0) begin n_fail++; $display("FAIL read_9th_released got=%b want=0", oe9); end
        n_cmp++; if (cnt_txr - txr0 !== 1) begin n_fail++; $display("FAIL read_tx_req_count got=%0d want=1", cnt_txr - txr0); end
        i2c_stop;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop got=%b want=0", busy); end
    endtask

    task automatic test_read_ack;
        logic ack, oe9;
        logic [7:0] d;
        int txr0;
        tx_data = 8'hAB;
        txr0 = cnt_txr;
        i2c_start;
        send_byte(8'hA1, ack);
        tx_data = 8'h5A;
        read_byte(1'b1, d, oe9);
        n_cmp++; if (d !== 8'hAB) begin n_fail++; $display("FAIL read2_first got=%h want=ab", d); end
        read_byte(1'b0, d, oe9);
        n_cmp++; if (d !== 8'h5A) begin n_fail++; $display("FAIL read2_second got=%h want=5a", d); end
        n_cmp++; if (oe9 !== 1'b0) begin n_fail++; $display("FAIL read2_9th_released got=%b want=0", oe9); end
        n_cmp++; if (cnt_txr - txr0 !== 2) begin n_fail++; $display("FAIL read2_tx_req_count got=%0d want=2", cnt_txr - txr0); end
        i2c_stop;
    endtask

    task automatic test_wrong_addr;
        logic ack;
        int oe0, rxv0, txr0;
        oe0 = cnt_oe; rxv0 = cnt_rxv; txr0 = cnt_txr;
        i2c_start;
        send_byte(8'hA2, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_ack got=%b want=1", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy got=%b want=0", busy); end
        send_byte(8'h3C, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_data_ack got=%b want=1", ack); end
        i2c_stop;
        n_cmp++; if (cnt_oe - oe0 !== 0) begin n_fail++; $display("FAIL wrong_addr_oe_cycles got=%0d want=0", cnt_oe - oe0); end
        n_cmp++; if (cnt_rxv - rxv0 !== 0) begin n_fail++; $display("FAIL wrong_addr_rx_valid got=%0d want=0", cnt_rxv - rxv0); end
        n_cmp++; if (cnt_txr - txr0 !== 0) begin n_fail++; $display("FAIL wrong_addr_tx_req got=%0d want=0", cnt_txr - txr0); end
    endtask

    task automatic test_repeated_start;
        logic ack, oe9;
        logic [7:0] d;
        tx_data = 8'hC3;
        i2c_start;
        send_byte(8'hA0, ack);
        send_byte(8'h11, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_write_ack got=%b want=0", ack); end
        n_cmp++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data got=%h want=11", rx_data); end
        i2c_start;
        send_byte(8'hA1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_read_addr_ack got=%b want=0", ack); end
        read_byte(1'b0, d, oe9);
        n_cmp++; if (d !== 8'hC3) begin n_fail++; $display("FAIL rs_read_byte got=%h want=c3", d); end
        i2c_stop;
        n_cmp++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data_kept got=%h want=11", rx_data); end
    endtask

    task automatic test_reset_mid_tx;
        logic ack;
        tx_data = 8'h00;
        i2c_start;
        send_byte(8'hA1, ack);
        wait_clk(2);
        n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_driving got=%b want=1", sda_oe); end
        rst = 1'b1;
        #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_release got=%b want=0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);
        i2c_stop;
        i2c_start;
        send_byte(8'hA0, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL midrst_next_addr_ack got=%b want=0", ack); end
        send_byte(8'h96, ack);
        n_cmp++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL midrst_next_rx_data got=%h want=96", rx_data); end
        i2c_stop;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_nack;
        test_read_ack;
        test_wrong_addr;
        test_repeated_start;
        test_reset_mid_tx;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
